// File: rtl/demux_pkg.sv
// Shared types and elaboration helpers for the 1:N stream demultiplexer.
package demux_pkg;

   typedef enum logic {
      DMX_SEL = 1'b0,
      DMX_RR  = 1'b1
   } demux_mode_e;

   // Pointer width that stays at least one bit even for degenerate channel counts.
   function automatic int clogSafe(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry output buffer for a single demux channel: loads a beat, holds it
// under backpressure and keeps the last value on the lane after draining.
module demux_chan_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic              inClk,
   input  logic              inRstN,
   input  logic              inLoad,
   input  logic [DATA_W-1:0] inData,
   input  logic              inReady,
   output logic              outValid,
   output logic [DATA_W-1:0] outData
);

   logic              slotValid_r;
   logic [DATA_W-1:0] slotData_r;
   logic              validNext_s;

   // Next valid: a load wins over a same-cycle drain so throughput stays at one beat per cycle.
   always_comb begin
      validNext_s = slotValid_r;
      if (inLoad) begin
         validNext_s = 1'b1;
      end else if (slotValid_r && inReady) begin
         validNext_s = 1'b0;
      end else begin
         validNext_s = slotValid_r;
      end
   end

   // Slot state register.
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         slotValid_r <= 1'b0;
         slotData_r  <= {DATA_W{1'b0}};
      end else begin
         slotValid_r <= validNext_s;
         if (inLoad) begin
            slotData_r <= inData;
         end else begin
            slotData_r <= slotData_r;
         end
      end
   end

   assign outValid = slotValid_r;
   assign outData  = slotData_r;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered, flow-controlled 1:N demultiplexer with explicit-select and
// round-robin routing, per-channel one-entry buffers and a dropped-beat counter.
module demux_stream_1ton
   import demux_pkg::*;
#(
   parameter int DATA_W = 1,
   parameter int N_CH   = 4,
   parameter int SEL_W  = clogSafe(N_CH),
   parameter int ERR_W  = 8
) (
   input  logic                     inClk,
   input  logic                     inRstN,
   input  logic                     inMode,
   input  logic [SEL_W-1:0]         inSel,
   input  logic                     inValid,
   input  logic [DATA_W-1:0]        inData,
   output logic                     outReady,
   input  logic [N_CH-1:0]          inReady,
   output logic [N_CH-1:0]          outValid,
   output logic [N_CH*DATA_W-1:0]   outData,
   output logic [SEL_W-1:0]         outPtr,
   output logic                     outErr,
   output logic [ERR_W-1:0]         outErrCnt
);

   localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   demux_mode_e       mode_s;
   logic [SEL_W-1:0]  tgt_s;
   logic              bad_s;
   logic              tgtReady_s;
   logic              ready_s;
   logic              accept_s;
   logic [N_CH-1:0]   load_s;
   logic [N_CH-1:0]   slotValid_s;
   logic [SEL_W-1:0]  ptr_r;
   logic              err_r;
   logic [ERR_W-1:0]  errCnt_r;

   assign mode_s = demux_mode_e'(inMode);

   // Target decode and flow control; an out-of-range select is always accepted so it can be dropped.
   always_comb begin
      tgt_s      = (mode_s == DMX_RR) ? ptr_r : inSel;
      bad_s      = (mode_s == DMX_SEL) && ({1'b0, inSel} >= CH_COUNT);
      tgtReady_s = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (tgt_s == SEL_W'(k)) begin
            tgtReady_s = ~slotValid_s[k] | inReady[k];
         end else begin
            tgtReady_s = tgtReady_s;
         end
      end
      ready_s  = bad_s | tgtReady_s;
      accept_s = inValid & ready_s;
   end

   // Per-channel load strobes.
   always_comb begin
      load_s = {N_CH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         load_s[k] = accept_s & ~bad_s & (tgt_s == SEL_W'(k));
      end
   end

   // Round-robin pointer: parked at channel 0 whenever explicit select is active.
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         ptr_r <= {SEL_W{1'b0}};
      end else if (mode_s == DMX_SEL) begin
         ptr_r <= {SEL_W{1'b0}};
      end else if (accept_s) begin
         ptr_r <= (ptr_r == LAST_CH) ? {SEL_W{1'b0}} : ptr_r + SEL_W'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Drop pulse and saturating drop counter.
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         err_r    <= 1'b0;
         errCnt_r <= {ERR_W{1'b0}};
      end else begin
         err_r <= accept_s & bad_s;
         if (accept_s && bad_s && (errCnt_r != ERR_MAX)) begin
            errCnt_r <= errCnt_r + ERR_W'(1);
         end else begin
            errCnt_r <= errCnt_r;
         end
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : gSlot
      demux_chan_slot #(
         .DATA_W (DATA_W)
      ) uSlot (
         .inClk    (inClk),
         .inRstN   (inRstN),
         .inLoad   (load_s[gi]),
         .inData   (inData),
         .inReady  (inReady[gi]),
         .outValid (slotValid_s[gi]),
         .outData  (outData[gi*DATA_W +: DATA_W])
      );
   end

   assign outReady  = ready_s;
   assign outValid  = slotValid_s;
   assign outPtr    = ptr_r;
   assign outErr    = err_r;
   assign outErrCnt = errCnt_r;

endmodule
